// File: rtl/booth_r4_seq_mult.sv
// Sequential radix-4 Booth multiplier, one digit per cycle, valid/ready at both ends.
// Optional BOOTH_EARLY_TERM_EN: finish as soon as the remaining multiplier bits are all-0 or all-1.
module booth_r4_seq_mult #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int EW = WIDTH + 2;
  localparam int AW = 2 * WIDTH + 4;
  localparam int D  = WIDTH / 2 + 1;
  localparam int CW = $clog2(D + 1);

  if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
    $fatal(1, "booth_r4_seq_mult: WIDTH must be even and >= 4");
  end

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t         state;
  logic [AW-1:0]  acc;
  logic [AW-1:0]  ash;
  logic [EW:0]    mreg;
  logic [CW-1:0]  cnt;

  logic [EW-1:0]  a_ext;
  logic [EW-1:0]  b_ext;
  logic           neg;
  logic           one;
  logic           two;
  logic [AW-1:0]  sel;
  logic [AW-1:0]  pp;
  logic           early;
  logic           finish;
  logic [AW-1:0]  fin_acc;

  // operand extension and Booth digit / partial product for current window
  always_comb begin
    a_ext   = signed_mode ? {{2{a[WIDTH-1]}}, a} : {2'b00, a};
    b_ext   = signed_mode ? {{2{b[WIDTH-1]}}, b} : {2'b00, b};
    neg     = mreg[2];
    one     = mreg[1] ^ mreg[0];
    two     = ~(one | ~(mreg[2] ^ mreg[1]));
    sel     = one ? ash : (two ? {ash[AW-2:0], 1'b0} : '0);
    pp      = neg ? (~sel + 1'b1) : sel;
    early   = 1'b0;
`ifdef BOOTH_EARLY_TERM_EN
    early   = (mreg == '0) || (&mreg);
`endif
    finish  = early || (cnt == CW'(D - 1));
    fin_acc = early ? acc : (acc + pp);
  end

  // control FSM with registered handshake outputs and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      product   <= '0;
      acc       <= '0;
      ash       <= '0;
      mreg      <= '0;
      cnt       <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            ash      <= {{(AW-EW){a_ext[EW-1]}}, a_ext};
            mreg     <= {b_ext, 1'b0};
            acc      <= '0;
            cnt      <= '0;
            state    <= CALC;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        CALC: begin
          acc  <= fin_acc;
          ash  <= {ash[AW-3:0], 2'b00};
          mreg <= {{2{mreg[EW]}}, mreg[EW:2]};
          cnt  <= cnt + 1'b1;
          if (finish) begin
            state     <= DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
            product   <= fin_acc[2*WIDTH-1:0];
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_r4_seq_mult.sv
// Bench for booth_r4_seq_mult: 8-bit directed table and sequences,
// 16-bit corner and random products against a plain integer multiply.
module tb_booth_r4_seq_mult;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  logic        iv8, ir8, sm8, ov8, or8, busy8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;

  logic        iv16, ir16, sm16, ov16, or16, busy16;
  logic [15:0] a16, b16;
  logic [31:0] p16;

  booth_r4_seq_mult #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv8), .in_ready(ir8),
    .a(a8), .b(b8), .signed_mode(sm8),
    .out_valid(ov8), .out_ready(or8),
    .product(p8), .busy(busy8)
  );

  booth_r4_seq_mult #(.WIDTH(16)) u16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv16), .in_ready(ir16),
    .a(a16), .b(b16), .signed_mode(sm16),
    .out_valid(ov16), .out_ready(or16),
    .product(p16), .busy(busy16)
  );

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        sm;
    logic [15:0] p;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic start8(input logic [7:0] ta, input logic [7:0] tb_,
                        input logic ts);
    @(negedge clk);
    a8 = ta; b8 = tb_; sm8 = ts; iv8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv8 = 1'b0;
    a8 = 8'($urandom);
    b8 = 8'($urandom);
    sm8 = ~ts;
  endtask

  task automatic wait8(output int k, output int bc);
    k = 0; bc = 0;
    while (!ov8 && k < 40) begin
      if (busy8) bc++;
      @(negedge clk);
      k++;
    end
  endtask

  task automatic run8(input vec_t v, input string nm);
    int k, bc;
    start8(v.a, v.b, v.sm);
    wait8(k, bc);
    chk({nm, " product"}, 32'(p8), 32'(v.p));
`ifndef BOOTH_EARLY_TERM_EN
    chk({nm, " latency"}, k, 5);
    chk({nm, " busy cycles"}, bc, 5);
`else
    chk({nm, " valid"}, 32'(ov8), 32'd1);
`endif
    @(negedge clk);
    chk({nm, " back to idle"}, {30'b0, ov8, ir8}, 32'b01);
  endtask

  task automatic run16(input logic [15:0] ta, input logic [15:0] tb_,
                       input logic ts, input string nm);
    int k;
    longint pa, pb;
    logic [31:0] exp;
    pa = ts ? longint'($signed(ta)) : longint'(ta);
    pb = ts ? longint'($signed(tb_)) : longint'(tb_);
    exp = 32'(pa * pb);
    @(negedge clk);
    a16 = ta; b16 = tb_; sm16 = ts; iv16 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv16 = 1'b0;
    k = 0;
    while (!ov16 && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk({nm, " product"}, p16, exp);
`ifndef BOOTH_EARLY_TERM_EN
    chk({nm, " latency"}, k, 9);
`else
    if (tb_ == 16'h0000) chk({nm, " early latency"}, k, 1);
    if (tb_ == 16'h7fff) chk({nm, " full latency"}, k, 9);
`endif
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] corners[4];
    int k, bc;

    vecs[0]  = '{8'h07, 8'hfd, 1'b1, 16'hffeb};
    vecs[1]  = '{8'h80, 8'h80, 1'b1, 16'h4000};
    vecs[2]  = '{8'hff, 8'hff, 1'b0, 16'hfe01};
    vecs[3]  = '{8'h12, 8'h34, 1'b0, 16'h03a8};
    vecs[4]  = '{8'h03, 8'h05, 1'b0, 16'h000f};
    vecs[5]  = '{8'hff, 8'hff, 1'b1, 16'h0001};
    vecs[6]  = '{8'h80, 8'h7f, 1'b1, 16'hc080};
    vecs[7]  = '{8'h00, 8'hab, 1'b1, 16'h0000};
    vecs[8]  = '{8'h7f, 8'h7f, 1'b0, 16'h3f01};
    vecs[9]  = '{8'h80, 8'hff, 1'b0, 16'h7f80};
    vecs[10] = '{8'hff, 8'h80, 1'b1, 16'h0080};
    vecs[11] = '{8'h05, 8'hfb, 1'b1, 16'hffe7};
    corners = '{16'h8000, 16'hffff, 16'h0000, 16'h7fff};

    iv8 = 0; a8 = 0; b8 = 0; sm8 = 0; or8 = 1;
    iv16 = 0; a16 = 0; b16 = 0; sm16 = 0; or16 = 1;

    repeat (2) @(negedge clk);
    chk("reset in_ready", 32'(ir8), 32'd1);
    chk("reset out_valid/busy", {30'b0, ov8, busy8}, 32'd0);
    chk("reset product", 32'(p8), 32'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) run8(vecs[i], $sformatf("vec%0d", i));

    // backpressure: product must hold while the consumer stalls
    or8 = 1'b0;
    start8(8'h12, 8'h34, 1'b0);
    wait8(k, bc);
    for (int c = 0; c < 10; c++) begin
      iv8 = 1'b1;
      a8 = 8'h55;
      chk($sformatf("stall%0d", c), {p8, 14'b0, ov8, ir8},
          {16'h03a8, 14'b0, 1'b1, 1'b0});
      @(negedge clk);
    end
    iv8 = 1'b0;
    or8 = 1'b1;
    @(negedge clk);
    chk("stall release", {30'b0, ov8, ir8}, 32'b01);
    @(negedge clk);

    // asynchronous reset in the middle of a calculation
    start8(8'h7b, 8'h6d, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort in_ready", 32'(ir8), 32'd1);
    chk("abort out_valid/busy", {30'b0, ov8, busy8}, 32'd0);
    chk("abort product", 32'(p8), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run8(vecs[4], "after abort");

    foreach (corners[i])
      foreach (corners[j]) begin
        run16(corners[i], corners[j], 1'b1, "w16 corner s");
        run16(corners[i], corners[j], 1'b0, "w16 corner u");
      end
    for (int n = 0; n < 2000; n++)
      run16(16'($urandom), 16'($urandom), 1'($urandom), $sformatf("w16 rnd%0d", n));

`ifdef BOOTH_EARLY_TERM_EN
    run16(16'h1234, 16'h0000, 1'b1, "early b0");
    run16(16'h1234, 16'h7fff, 1'b1, "early b7fff");
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
